cargador_instrucciones: RTL and testbench
=========================================

# cargador_instrucciones

Boot-time program loader that sits directly upstream of the instruction memory of the single-cycle processor. It accepts a byte stream, typically from a UART receiver, over a valid/ready handshake. It assembles big-endian 32-bit instruction words and writes them through a one-cycle write port into consecutive word addresses starting at 0. The processor is held in reset until a complete program has been loaded.

## Interface
- `ADDR_W`, 6: instruction-memory word-address width.
- `DEPTH`, 64: maximum words per program. Must satisfy DEPTH ≤ 2^ADDR_W.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (low = reset).
- `rx_dato`  in  8  incoming byte.
- `rx_valido`  in  1  `rx_dato` is valid; the source holds it until accepted.
- `rx_listo`  out  1  loader can accept a byte this cycle.
- `cargar`  in  1  reload request; honoured only in FIN or ERROR.
- `mem_escr`  out  1  instruction-memory write enable, one-cycle pulse.
- `mem_dir`  out  ADDR_W  write word address.
- `mem_dato`  out  32  write data.
- `cpu_reset`  out  1  high holds the processor (PC and register bank) in reset.
- `cargado`  out  1  program fully loaded.
- `error`  out  1  sticky: header word count exceeds DEPTH.
- `palabras`  out  ADDR_W+1  number of words written in the current load.

## Operation
- **Stream format**
  - 16-bit word count N, big-endian: high byte first.
  - Then N×4 bytes; within each word the first byte goes to [31:24].
- **Byte acceptance:** a byte is accepted on a rising edge where `rx_valido && rx_listo`. Valid with `rx_listo`=0 is ignored and the byte is not consumed.
- **States**
  - CAB_H: accept high count byte → CAB_L.
  - CAB_L: accept low count byte, then branch:
    - N=0 → FIN.
    - N>DEPTH → ERROR.
    - otherwise → DATOS with byte index 0.
  - DATOS: accept a byte into the shift register and increment the byte index. On the 4th byte → ESCRIBE.
  - ESCRIBE: assert the write for one cycle, increment `palabras`, then branch:
    - `palabras`+1 == N → FIN.
    - otherwise → DATOS.
  - FIN: `cargado`=1, `cpu_reset`=0. `cargar`=1 → CAB_H.
  - ERROR: `error`=1, `cpu_reset`=1. `cargar`=1 → CAB_H.
- **Reload clearing:** leaving FIN or ERROR via `cargar` clears `palabras`, `cargado` and `error`.
- **Instruction memory:** contents are never cleared by the loader.
- **`cargar` outside FIN/ERROR:** ignored.
- **Output registration:** all outputs are registered. `rx_listo` is derived from the next state; it is 1 only when the next state is CAB_H, CAB_L or DATOS.

## Timing
- **Reset values** (asserted asynchronously while `reset`=0):
  - `rx_listo`=0, `mem_escr`=0, `mem_dir`=0, `mem_dato`=0.
  - `cpu_reset`=1, `cargado`=0, `error`=0, `palabras`=0.
  - state = CAB_H.
- **After reset release:** `rx_listo` rises on the first rising edge after `reset` goes high.
- **Per-word throughput:** at most 4 accept cycles followed by 1 write cycle. `rx_listo`=0 during the write cycle.
- **Write latency:**
  - `mem_escr`=1 in the cycle immediately after the edge that accepts the 4th byte.
  - `mem_dir` = `palabras` before the increment; `mem_dato` = the assembled word. Both are stable while `mem_escr`=1.
  - `mem_escr` is never high for two consecutive cycles.
- **`cpu_reset` release:** `cpu_reset` falls in the cycle after the last write (or after the CAB_L accept when N=0), together with `cargado` rising.
- **ERROR entry:** `error` rises one cycle after the CAB_L accept. No write occurs and `rx_listo` stays 0.
- **Reload via `cargar`:** `cpu_reset` rises and `cargado` falls in the cycle after `cargar` is sampled high. `rx_listo` rises in the same cycle.
- **Reset mid-operation:** any partial header or word is discarded. If `reset` asserts during ESCRIBE, `mem_escr` drops immediately (asynchronously). The next load restarts at CAB_H and address 0.
- **Byte index:** wraps 3→0 only via ESCRIBE; no byte is ever accepted in ESCRIBE.

## Test plan
- **Two-word load:** reset, then send 00 02 8C 01 00 04 00 22 18 20 with `rx_valido` held high.
  - Two `mem_escr` pulses: (dir 0, 0x8C010004) then (dir 1, 0x00221820), separated by 4 accept cycles.
  - Final state: `palabras`=2, `cargado`=1, `cpu_reset`=0.
- **Empty program:** send 00 00.
  - No `mem_escr` pulse.
  - `cargado`=1 and `cpu_reset`=0 one cycle after the second byte.
- **Oversize count:** send 00 41 with DEPTH=64.
  - `error`=1, `rx_listo`=0, `cpu_reset`=1, no writes.
  - Pulse `cargar` → `error`=0 and `rx_listo`=1 the next cycle.
- **Handshake gaps:** random `rx_valido` gaps, plus `rx_valido` held high through ESCRIBE on a one-word load (00 01 AA BB CC DD).
  - The held byte is not consumed during ESCRIBE.
  - Word written = 0xAABBCCDD at dir 0.
- **Reset mid-word:** assert `reset` low after 00 03 plus 2 data bytes.
  - All outputs go to reset values immediately.
  - Reload with 00 01 11 22 33 44 → single write (dir 0, 0x11223344).
- **Full-depth reload:** after FIN, pulse `cargar` and load N=64 sequential words (value = index).
  - `cpu_reset`=1 throughout the load.
  - Last write is (dir 63, 0x0000003F), then `palabras`=64 and `cargado`=1.

Source files
------------

// File: rtl/cargador_instrucciones_if.sv
// Byte-stream handshake and instruction-memory write port of the program loader.
interface cargador_instrucciones_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_dato;
  logic              rx_valido;
  logic              rx_listo;
  logic              mem_escr;
  logic [ADDR_W-1:0] mem_dir;
  logic [31:0]       mem_dato;

  // Loader side: consumes bytes, drives the memory write port.
  modport slave (
    input  rx_dato, rx_valido,
    output rx_listo, mem_escr, mem_dir, mem_dato
  );

  // Environment side: byte source plus instruction memory.
  modport master (
    output rx_dato, rx_valido,
    input  rx_listo, mem_escr, mem_dir, mem_dato
  );
endinterface

// File: rtl/cargador_instrucciones.sv
// Boot-time program loader: assembles big-endian words from a byte stream
// (16-bit word count header, then the words) and writes them to instruction
// memory from address 0, holding the CPU in reset until the load completes.
module cargador_instrucciones #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic                clk,
  input  logic                reset,
  cargador_instrucciones_if.slave bus,
  input  logic                cargar,
  output logic                cpu_reset,
  output logic                cargado,
  output logic                error,
  output logic [ADDR_W:0]     palabras
);

  typedef enum logic [2:0] {CAB_H, CAB_L, DATOS, ESCRIBE, FIN, ERROR} estado_t;

  estado_t           state_q, state_d;
  logic [15:0]       cuenta_q, cuenta_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W:0]   palabras_q, palabras_d;
  logic              rx_listo_q, rx_listo_d;
  logic              mem_escr_q, mem_escr_d;
  logic [ADDR_W-1:0] mem_dir_q, mem_dir_d;
  logic [31:0]       mem_dato_q, mem_dato_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              cargado_q, cargado_d;
  logic              error_q, error_d;
  logic              aceptar;
  logic [15:0]       n_cab;

  // Next-state and registered-output computation; outputs follow the next state.
  always_comb begin
    state_d    = state_q;
    cuenta_d   = cuenta_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    palabras_d = palabras_q;
    mem_dir_d  = mem_dir_q;
    mem_dato_d = mem_dato_q;
    aceptar    = bus.rx_valido && rx_listo_q;
    n_cab      = {cuenta_q[15:8], bus.rx_dato};

    case (state_q)
      CAB_H: if (aceptar) begin
        cuenta_d = {bus.rx_dato, 8'h00};
        state_d  = CAB_L;
      end
      CAB_L: if (aceptar) begin
        cuenta_d = n_cab;
        idx_d    = '0;
        if (n_cab == 16'd0)                 state_d = FIN;
        else if (32'(n_cab) > 32'(DEPTH))   state_d = ERROR;
        else                                state_d = DATOS;
      end
      DATOS: if (aceptar) begin
        shift_d = {shift_q[15:0], bus.rx_dato};
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          // Address and word are captured here so they are stable for the whole write cycle.
          mem_dato_d = {shift_q, bus.rx_dato};
          mem_dir_d  = palabras_q[ADDR_W-1:0];
          state_d    = ESCRIBE;
        end
      end
      ESCRIBE: begin
        palabras_d = palabras_q + {{ADDR_W{1'b0}}, 1'b1};
        if ((32'(palabras_q) + 32'd1) == 32'(cuenta_q)) state_d = FIN;
        else                                             state_d = DATOS;
      end
      FIN, ERROR: if (cargar) begin
        palabras_d = '0;
        state_d    = CAB_H;
      end
      default: state_d = CAB_H;
    endcase

    rx_listo_d  = (state_d == CAB_H) || (state_d == CAB_L) || (state_d == DATOS);
    mem_escr_d  = (state_d == ESCRIBE);
    cargado_d   = (state_d == FIN);
    error_d     = (state_d == ERROR);
    cpu_reset_d = (state_d != FIN);
  end

  // State and output registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CAB_H;
      cuenta_q    <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      palabras_q  <= '0;
      rx_listo_q  <= 1'b0;
      mem_escr_q  <= 1'b0;
      mem_dir_q   <= '0;
      mem_dato_q  <= '0;
      cpu_reset_q <= 1'b1;
      cargado_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cuenta_q    <= cuenta_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      palabras_q  <= palabras_d;
      rx_listo_q  <= rx_listo_d;
      mem_escr_q  <= mem_escr_d;
      mem_dir_q   <= mem_dir_d;
      mem_dato_q  <= mem_dato_d;
      cpu_reset_q <= cpu_reset_d;
      cargado_q   <= cargado_d;
      error_q     <= error_d;
    end
  end

  assign bus.rx_listo = rx_listo_q;
  assign bus.mem_escr = mem_escr_q;
  assign bus.mem_dir  = mem_dir_q;
  assign bus.mem_dato = mem_dato_q;
  assign cpu_reset    = cpu_reset_q;
  assign cargado      = cargado_q;
  assign error        = error_q;
  assign palabras     = palabras_q;

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Self-checking bench for the program loader: random byte gaps, a queue of
// expected memory writes built from each program, and directed corner cases.
module tb_cargador_instrucciones;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic          clk;
  logic          reset;
  logic          cargar;
  logic          cpu_reset;
  logic          cargado;
  logic          error;
  logic [ADDR_W:0] palabras;

  cargador_instrucciones_if #(.ADDR_W(ADDR_W)) bus ();

  cargador_instrucciones #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .cargar   (cargar),
    .cpu_reset(cpu_reset),
    .cargado  (cargado),
    .error    (error),
    .palabras (palabras)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: expected (address, word) writes in order.
  int unsigned   exp_dir[$];
  logic [31:0]   exp_dato[$];
  logic [31:0]   prog[$];
  int unsigned   gap_max = 0;
  bit            cargar_mid = 0;
  int unsigned   cyc = 0;
  int unsigned   wc_prev = 0;
  int unsigned   wc_last = 0;
  logic          escr_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every pulse must match the next expected write.
  always @(negedge clk) begin
    cyc++;
    if (bus.mem_escr === 1'b1) begin
      wc_prev = wc_last;
      wc_last = cyc;
      check("escr_consecutivo", {31'd0, escr_prev}, 32'd0);
      check("cpu_reset_en_carga", {31'd0, cpu_reset}, 32'd1);
      check("rx_listo_en_escr", {31'd0, bus.rx_listo}, 32'd0);
      if (exp_dir.size() == 0) begin
        check("escr_inesperada", 32'd1, 32'd0);
      end else begin
        check("mem_dir", 32'(bus.mem_dir), 32'(exp_dir.pop_front()));
        check("mem_dato", bus.mem_dato, exp_dato.pop_front());
      end
    end
    escr_prev = bus.mem_escr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned g = (gap_max == 0) ? 0 : $urandom_range(0, gap_max);
    repeat (g) begin
      bus.rx_valido = 1'b0;
      @(negedge clk);
    end
    bus.rx_dato   = b;
    bus.rx_valido = 1'b1;
    for (int i = 0; i < 20 && bus.rx_listo !== 1'b1; i++) @(negedge clk);
    if (bus.rx_listo !== 1'b1) check("rx_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_rx_listo", {31'd0, bus.rx_listo}, 32'd0);
    check("rst_mem_escr", {31'd0, bus.mem_escr}, 32'd0);
    check("rst_mem_dir", 32'(bus.mem_dir), 32'd0);
    check("rst_mem_dato", bus.mem_dato, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_cargado", {31'd0, cargado}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_palabras", 32'(palabras), 32'd0);
  endtask

  task automatic reload();
    bus.rx_valido = 1'b0;
    cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
    check("recarga_rx_listo", {31'd0, bus.rx_listo}, 32'd1);
    check("recarga_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("recarga_cargado", {31'd0, cargado}, 32'd0);
    check("recarga_error", {31'd0, error}, 32'd0);
    check("recarga_palabras", 32'(palabras), 32'd0);
  endtask

  task automatic load_prog();
    int unsigned n = prog.size();
    logic [31:0] w;
    for (int unsigned i = 0; i < n; i++) begin
      exp_dir.push_back(i);
      exp_dato.push_back(prog[i]);
    end
    send_byte(8'(n >> 8));
    if (cargar_mid) begin
      bus.rx_valido = 1'b0;
      cargar = 1'b1;
      @(negedge clk);
      cargar = 1'b0;
    end
    send_byte(8'(n));
    for (int unsigned i = 0; i < n; i++) begin
      w = prog[i];
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
    end
    if (n > 0) begin
      check("cpu_reset_ultima_escr", {31'd0, cpu_reset}, 32'd1);
      check("cargado_ultima_escr", {31'd0, cargado}, 32'd0);
      @(negedge clk);
    end
    check("fin_cargado", {31'd0, cargado}, 32'd1);
    check("fin_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("fin_palabras", 32'(palabras), n);
    check("fin_rx_listo", {31'd0, bus.rx_listo}, 32'd0);
    check("fin_error", {31'd0, error}, 32'd0);
    check("escr_pendientes", exp_dir.size(), 32'd0);
    bus.rx_valido = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cargar = 1'b0;
    bus.rx_valido = 1'b0;
    bus.rx_dato = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b1;
    @(negedge clk);
    check("rx_listo_tras_reset", {31'd0, bus.rx_listo}, 32'd1);

    // Two-word load with valid held high; cargar in CAB_L must be ignored.
    gap_max = 0;
    cargar_mid = 1;
    prog = '{32'h8C010004, 32'h00221820};
    load_prog();
    cargar_mid = 0;
    check("separacion_escr", wc_last - wc_prev, 32'd5);

    // Empty program.
    reload();
    prog = {};
    load_prog();

    // Oversize count.
    reload();
    send_byte(8'h00);
    send_byte(8'h41);
    bus.rx_valido = 1'b0;
    check("ovf_error", {31'd0, error}, 32'd1);
    check("ovf_rx_listo", {31'd0, bus.rx_listo}, 32'd0);
    check("ovf_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    repeat (3) @(negedge clk);
    check("ovf_error_fijo", {31'd0, error}, 32'd1);
    check("ovf_cargado", {31'd0, cargado}, 32'd0);
    reload();

    // Random gaps, then a one-word load with valid held through ESCRIBE and after.
    gap_max = 3;
    prog = {};
    for (int i = 0; i < 5; i++) prog.push_back($urandom);
    load_prog();
    reload();
    gap_max = 0;
    prog = '{32'hAABBCCDD};
    load_prog();
    bus.rx_dato = 8'hEE;
    bus.rx_valido = 1'b1;
    repeat (3) @(negedge clk);
    check("retenido_rx_listo", {31'd0, bus.rx_listo}, 32'd0);
    check("retenido_cargado", {31'd0, cargado}, 32'd1);
    bus.rx_valido = 1'b0;

    // Reset mid-word.
    reload();
    gap_max = 2;
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h12);
    send_byte(8'h34);
    bus.rx_valido = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    prog = '{32'h11223344};
    load_prog();

    // Reset asserted during the write cycle drops mem_escr at once.
    reload();
    exp_dir.push_back(0);
    exp_dato.push_back(32'hCAFEF00D);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hF0);
    send_byte(8'h0D);
    bus.rx_valido = 1'b0;
    check("escr_antes_reset", {31'd0, bus.mem_escr}, 32'd1);
    #2 reset = 1'b0;
    #1 check("escr_reset_async", {31'd0, bus.mem_escr}, 32'd0);
    check("palabras_reset_async", 32'(palabras), 32'd0);
    check("pend_reset_escr", exp_dir.size(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Short load to reach FIN, then full-depth reload with index-valued words.
    gap_max = 1;
    prog = '{$urandom};
    load_prog();
    reload();
    prog = {};
    for (int unsigned i = 0; i < DEPTH; i++) prog.push_back(i);
    load_prog();
    check("ultima_dir", 32'(bus.mem_dir), 32'd63);
    check("ultimo_dato", bus.mem_dato, 32'h0000003F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
